// File: rtl/draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter_if
// Description : Bundles the three drawing requesters and the shared VGA write
//               port of the draw arbiter.
//               master - requester side (drives req/done/pixel data, observes
//                        grant, VGA port and status)
//               slave  - arbiter side
//               Signals:
//                 req[2:0], done[2:0], we_in[2:0]  per-requester control
//                 x0..x2, y0..y2 [9:0], c0..c2 [2:0] per-requester pixel data
//                 grant[2:0]                        one-hot owner
//                 vga_we, vga_x, vga_y, vga_color   shared VGA write port
//                 busy, timeout                     status
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_arbiter_if;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] we_in;
  logic [9:0] x0;
  logic [9:0] x1;
  logic [9:0] x2;
  logic [9:0] y0;
  logic [9:0] y1;
  logic [9:0] y2;
  logic [2:0] c0;
  logic [2:0] c1;
  logic [2:0] c2;
  logic [2:0] grant;
  logic       vga_we;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic [2:0] vga_color;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done, we_in, x0, x1, x2, y0, y1, y2, c0, c1, c2,
    input  grant, vga_we, vga_x, vga_y, vga_color, busy, timeout
  );

  modport slave (
    input  req, done, we_in, x0, x1, x2, y0, y1, y2, c0, c1, c2,
    output grant, vga_we, vga_x, vga_y, vga_color, busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter
// Description : Round-robin arbiter giving one of three drawing engines
//               (ball, paddle, brick) exclusive use of the VGA pixel write
//               port. A grant is held until the owner signals done or a
//               watchdog of MAX_HOLD active cycles expires.
//               Ports:
//                 clk    - system clock, rising edge
//                 resetn - asynchronous active-low reset
//                 bus    - draw_arbiter_if.slave (requesters + VGA port)
// Revision    : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
  parameter logic [19:0] MAX_HOLD = 20'd1000
) (
  input  logic          clk,
  input  logic          resetn,
  draw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [19:0] C_HOLD_LAST = MAX_HOLD - 20'd1;

  state_t      r_state;
  logic [2:0]  r_grant;
  logic [1:0]  r_last;
  logic [19:0] r_cnt;
  logic        r_timeout;

  logic [2:0]  w_pick;
  logic [1:0]  w_gidx;
  logic        w_done_g;
  logic        w_we_g;

  // Priority order rotates so the requester after the most recent owner is
  // tried first.
  always_comb begin
    w_pick = 3'b000;
    case (r_last)
      2'd0: begin
        if      (bus.req[1]) w_pick = 3'b010;
        else if (bus.req[2]) w_pick = 3'b100;
        else if (bus.req[0]) w_pick = 3'b001;
      end
      2'd1: begin
        if      (bus.req[2]) w_pick = 3'b100;
        else if (bus.req[0]) w_pick = 3'b001;
        else if (bus.req[1]) w_pick = 3'b010;
      end
      default: begin
        if      (bus.req[0]) w_pick = 3'b001;
        else if (bus.req[1]) w_pick = 3'b010;
        else if (bus.req[2]) w_pick = 3'b100;
      end
    endcase
  end

  assign w_gidx   = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);
  // Masking with the grant keeps done/we_in of other requesters out.
  assign w_done_g = |(bus.done & r_grant);
  assign w_we_g   = |(bus.we_in & r_grant);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_grant   <= 3'b000;
      r_last    <= 2'd2;
      r_cnt     <= 20'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state <= S_GRANT;
            r_grant <= w_pick;
            r_cnt   <= 20'd0;
          end
        end
        S_GRANT: begin
          if (w_done_g) begin
            r_state <= S_RELEASE;
            r_grant <= 3'b000;
            r_last  <= w_gidx;
          end else begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          r_cnt <= r_cnt + 20'd1;
          if (w_done_g) begin
            // done wins over a coincident watchdog expiry
            r_state <= S_RELEASE;
            r_grant <= 3'b000;
            r_last  <= w_gidx;
          end else if (r_cnt == C_HOLD_LAST) begin
            r_state   <= S_RELEASE;
            r_grant   <= 3'b000;
            r_last    <= w_gidx;
            r_timeout <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.timeout   = r_timeout;
  assign bus.vga_we    = (r_state == S_ACTIVE) && w_we_g;
  // One-hot AND-OR mux; all-zero grant yields all-zero pixel data.
  assign bus.vga_x     = ({10{r_grant[0]}} & bus.x0) |
                         ({10{r_grant[1]}} & bus.x1) |
                         ({10{r_grant[2]}} & bus.x2);
  assign bus.vga_y     = ({10{r_grant[0]}} & bus.y0) |
                         ({10{r_grant[1]}} & bus.y1) |
                         ({10{r_grant[2]}} & bus.y2);
  assign bus.vga_color = ({3{r_grant[0]}} & bus.c0) |
                         ({3{r_grant[1]}} & bus.c1) |
                         ({3{r_grant[2]}} & bus.c2);

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_arbiter
// Description : Self-checking bench for draw_arbiter. A transaction-level
//               model (owner / age-of-grant / cooldown) predicts every output
//               each cycle; directed scenarios pin the model with literal
//               expectations, followed by randomized traffic with occasional
//               asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

  localparam int C_MAX_HOLD = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  draw_arbiter_if bus ();

  draw_arbiter #(
    .MAX_HOLD (20'(C_MAX_HOLD))
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // has   : someone owns the port
  // owner : index of the owner
  // age   : edges since the grant was issued (0 = load cycle, k = k-th draw cycle)
  // last  : most recent owner
  // cool  : the single post-release cycle
  // tmo   : release in the previous edge was forced by the watchdog
  typedef struct packed {
    logic       has;
    logic [1:0] owner;
    logic [7:0] age;
    logic [1:0] last;
    logic       cool;
    logic       tmo;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r       = '0;
    r.last  = 2'd2;
    return r;
  endfunction

  function automatic model_t step(model_t s, logic [2:0] req, logic [2:0] done);
    model_t n;
    logic   found;
    int     k;
    n     = s;
    n.tmo = 1'b0;
    found = 1'b0;
    if (s.cool) begin
      n.cool = 1'b0;
    end else if (s.has) begin
      if (done[s.owner]) begin
        n.has = 1'b0; n.last = s.owner; n.cool = 1'b1;
      end else if (int'(s.age) == C_MAX_HOLD) begin
        n.has = 1'b0; n.last = s.owner; n.cool = 1'b1; n.tmo = 1'b1;
      end else begin
        n.age = s.age + 8'd1;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        k = (int'(s.last) + i) % 3;
        if (!found && req[k]) begin
          found   = 1'b1;
          n.has   = 1'b1;
          n.owner = 2'(k);
          n.age   = 8'd0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= model_reset();
    else         m <= step(m, bus.req, bus.done);
  end

  function automatic int e_grant(model_t s);
    return s.has ? (1 << s.owner) : 0;
  endfunction

  function automatic int e_we(model_t s, logic [2:0] we);
    return (s.has && s.age >= 8'd1 && we[s.owner]) ? 1 : 0;
  endfunction

  function automatic int e_sel(model_t s, int a, int b, int c);
    if (!s.has)          return 0;
    if (s.owner == 2'd0) return a;
    if (s.owner == 2'd1) return b;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_grant", int'(bus.grant), e_grant(m));
      chk("m_busy", int'(bus.busy), int'(m.has || m.cool));
      chk("m_timeout", int'(bus.timeout), int'(m.tmo));
      chk("m_vga_we", int'(bus.vga_we), e_we(m, bus.we_in));
      chk("m_vga_x", int'(bus.vga_x), e_sel(m, int'(bus.x0), int'(bus.x1), int'(bus.x2)));
      chk("m_vga_y", int'(bus.vga_y), e_sel(m, int'(bus.y0), int'(bus.y1), int'(bus.y2)));
      chk("m_vga_color", int'(bus.vga_color), e_sel(m, int'(bus.c0), int'(bus.c1), int'(bus.c2)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_inputs();
    bus.req = 3'b000; bus.done = 3'b000; bus.we_in = 3'b000;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0;
    bus.c0 = '0; bus.c1 = '0; bus.c2 = '0;
  endtask

  int n_act;
  int seen [4];
  int n_seen;

  initial begin
    resetn = 1'b0;
    zero_inputs();
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #3;
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_vga_we", int'(bus.vga_we), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    cyc();
    resetn = 1'b1;

    // Single request from requester 2, done after 5 draw cycles
    cyc();
    bus.req = 3'b100; bus.we_in = 3'b111;
    bus.x2 = 10'd777; bus.y2 = 10'd555; bus.c2 = 3'd5;
    cyc();
    bus.req = 3'b000;
    #1;
    chk("a_grant", int'(bus.grant), 4);
    chk("a_busy", int'(bus.busy), 1);
    chk("a_we_in_grant", int'(bus.vga_we), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.we_in = (k % 2 == 1) ? 3'b111 : 3'b011;
      bus.done  = (k == 4) ? 3'b100 : 3'b000;
      #1;
      chk("a_vga_we", int'(bus.vga_we), k % 2);
      chk("a_hold", int'(bus.grant), 4);
    end
    chk("a_vga_x", int'(bus.vga_x), 777);
    cyc();
    bus.done = 3'b000;
    #1;
    chk("a_rel_grant", int'(bus.grant), 0);
    chk("a_rel_busy", int'(bus.busy), 1);
    cyc();
    #1;
    chk("a_idle_busy", int'(bus.busy), 0);

    // Isolation: requester 1 owns the port while others assert we_in
    bus.we_in = 3'b101;
    bus.x0 = 10'd11;  bus.x1 = 10'd222; bus.x2 = 10'd333;
    bus.y0 = 10'd44;  bus.y1 = 10'd555; bus.y2 = 10'd666;
    bus.c0 = 3'd1;    bus.c1 = 3'd6;    bus.c2 = 3'd3;
    bus.req = 3'b010;
    cyc();
    bus.req = 3'b000;
    #1;
    chk("b_grant", int'(bus.grant), 2);
    cyc();
    #1;
    chk("b_vga_we", int'(bus.vga_we), 0);
    chk("b_vga_x", int'(bus.vga_x), 222);
    chk("b_vga_y", int'(bus.vga_y), 555);
    chk("b_vga_color", int'(bus.vga_color), 6);
    bus.done = 3'b010;
    cyc();
    bus.done = 3'b000;
    cyc();

    // Watchdog: requester 0 never finishes
    bus.req = 3'b001;
    cyc();
    bus.req = 3'b000;
    #1;
    chk("c_grant", int'(bus.grant), 1);
    n_act = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      if (bus.grant == 3'b001) n_act++;
      else break;
    end
    chk("c_active_cycles", n_act, C_MAX_HOLD);
    chk("c_timeout_pulse", int'(bus.timeout), 1);
    bus.req = 3'b111;
    cyc();
    #1;
    chk("c_timeout_end", int'(bus.timeout), 0);
    chk("c_idle_grant", int'(bus.grant), 0);
    cyc();
    #1;
    chk("c_next_rr", int'(bus.grant), 2);
    bus.done = 3'b010;
    cyc();
    bus.done = 3'b000; bus.req = 3'b000;
    cyc();

    // done coincident with watchdog expiry is a normal completion
    bus.req = 3'b100;
    cyc();
    bus.req = 3'b000;
    for (int i = 0; i < C_MAX_HOLD; i++) begin
      cyc();
      if (i == C_MAX_HOLD - 1) bus.done = 3'b100;
    end
    #1;
    chk("g_still_held", int'(bus.grant), 4);
    cyc();
    bus.done = 3'b000;
    #1;
    chk("g_no_timeout", int'(bus.timeout), 0);
    chk("g_released", int'(bus.grant), 0);
    cyc();

    // Round-robin under simultaneous requests after reset
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    bus.req = 3'b111; bus.done = 3'b111;
    n_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      #1;
      if (bus.grant != 3'b000 && n_seen < 4) begin
        seen[n_seen] = int'(bus.grant);
        n_seen++;
      end
    end
    chk("d_grant_count", n_seen, 4);
    chk("d_grant0", seen[0], 1);
    chk("d_grant1", seen[1], 2);
    chk("d_grant2", seen[2], 4);
    chk("d_grant3", seen[3], 1);
    bus.req = 3'b000; bus.done = 3'b000;
    cyc(); cyc(); cyc();

    // Asynchronous reset in the 3rd draw cycle
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    bus.req = 3'b011; bus.we_in = 3'b111;
    cyc();
    cyc();
    cyc();
    cyc();
    #1;
    chk("e_pre_vga_we", int'(bus.vga_we), 1);
    resetn = 1'b0;
    #1;
    chk("e_async_grant", int'(bus.grant), 0);
    chk("e_async_vga_we", int'(bus.vga_we), 0);
    chk("e_async_busy", int'(bus.busy), 0);
    cyc();
    resetn = 1'b1;
    cyc();
    #1;
    chk("e_first_grant", int'(bus.grant), 1);
    bus.req = 3'b000; bus.done = 3'b001;
    cyc();
    bus.done = 3'b000;
    cyc(); cyc();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc();
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      bus.req   = 3'($urandom_range(0, 7));
      bus.done  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      bus.we_in = 3'($urandom_range(0, 7));
      bus.x0 = 10'($urandom); bus.x1 = 10'($urandom); bus.x2 = 10'($urandom);
      bus.y0 = 10'($urandom); bus.y1 = 10'($urandom); bus.y2 = 10'($urandom);
      bus.c0 = 3'($urandom);  bus.c1 = 3'($urandom);  bus.c2 = 3'($urandom);
    end
    resetn = 1'b1;
    cyc();
    cyc();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 20'd1000: watchdog limit in clk cycles for one grant.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  per-requester draw request; bit0 ball, bit1 paddle, bit2 brick.
REQ-005 done  input  3  per-requester "drawing finished" indication.
REQ-006 we_in  input  3  per-requester pixel write enable.
REQ-007 x0, x1, x2  input  10 each  per-requester pixel x.
REQ-008 y0, y1, y2  input  10 each  per-requester pixel y.
REQ-009 c0, c1, c2  input  3 each  per-requester pixel colour.
REQ-010 grant  output  3  one-hot registered grant; all-zero when no owner.
REQ-011 vga_we, vga_x, vga_y, vga_color  output  1/10/10/3  shared VGA write port.
REQ-012 busy  output  1  high whenever state is not S_IDLE.
REQ-013 timeout  output  1  one-cycle pulse on watchdog release.

Function
REQ-014 FSM states SHALL be S_IDLE, S_GRANT, S_ACTIVE, S_RELEASE.
REQ-015 S_IDLE: req == 0 -> stay; any req bit set -> S_GRANT, with the grant register loaded at the same edge.
REQ-016 Winner selection SHALL be round-robin: search starts at index (last+1) mod 3 and wraps; last = index of the most recent grant.
REQ-017 Request-to-grant latency SHALL be exactly 1 cycle: req sampled high at edge N -> grant valid after edge N.
REQ-018 S_GRANT SHALL last exactly 1 cycle (the requester load cycle), then go to S_ACTIVE.
REQ-019 In S_GRANT, vga_we SHALL be 0.
REQ-020 In S_ACTIVE, vga_we SHALL be we_in[g]; vga_x/vga_y/vga_color SHALL be the granted requester's inputs, combinationally.
REQ-021 Outside S_ACTIVE, vga_we SHALL be 0; vga_x, vga_y and vga_color SHALL be 0 whenever grant == 0.
REQ-022 done[g] sampled high in S_GRANT or S_ACTIVE -> S_RELEASE; grant cleared at that edge; last <= g.
REQ-023 done bits of non-granted requesters SHALL be ignored.
REQ-024 we_in of non-granted requesters SHALL never reach vga_we.
REQ-025 A 20-bit hold counter SHALL clear on entry to S_GRANT and increment each S_ACTIVE cycle.
REQ-026 Counter == MAX_HOLD-1 in S_ACTIVE without done[g] -> S_RELEASE, grant cleared, last <= g, timeout = 1 for that one cycle.
REQ-027 done[g] coincident with watchdog expiry SHALL count as normal completion: timeout stays 0.
REQ-028 S_RELEASE SHALL last 1 cycle (vga_we = 0), then S_IDLE; no direct re-grant.
REQ-029 req deasserted by the owner while granted SHALL NOT release the grant; only done or the watchdog releases it.
REQ-030 Simultaneous requests SHALL be resolved solely by REQ-016; grant SHALL never have more than one bit set.

Reset
REQ-031 resetn low SHALL immediately force: state S_IDLE, grant 0, last 2 (so requester 0 wins first), counter 0, timeout 0, busy 0, vga_we 0, vga_x/vga_y/vga_color 0.
REQ-032 Reset asserted mid-grant SHALL abort the transfer with no further vga_we; after release, arbitration restarts per REQ-031.

Verification
REQ-033 Single request: req=3'b100 from idle, done[2] after 5 ACTIVE cycles -> grant=100 next cycle; vga_we follows we_in[2] for those 5 cycles; S_RELEASE; busy low 2 cycles after done.
REQ-034 Simultaneous req=3'b111 held after reset -> grants in order 001, 010, 100, 001, each separated by S_RELEASE and S_IDLE.
REQ-035 Isolation: requester 1 granted while we_in=3'b101 with distinct x/y/c values -> vga_we=0 and vga_x/vga_y/vga_color equal x1/y1/c1.
REQ-036 Watchdog with MAX_HOLD=8: no done -> release after 8 ACTIVE cycles; timeout is a 1-cycle pulse; next grant goes to the next requester in round-robin order.
REQ-037 Async reset in the 3rd ACTIVE cycle -> grant, vga_we and busy go 0 before the next clk edge; the first grant after reset goes to req bit0 when req=3'b011.
